// File: rtl/ahfp_pkg.sv
// Shared types and constants for the ahfp single-precision datapaths (adder and subtractor).
package ahfp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
    } ahfp_unpacked_t;

    // Zero and denormal encodings collapse to a signed zero with no mantissa.
    function automatic ahfp_unpacked_t ahfp_unpack(input logic [31:0] f);
        ahfp_unpacked_t u;
        u.sign = f[31];
        u.exp  = f[30:23];
        if (f[30:23] != 8'd0) begin
            u.man = {1'b1, f[22:0]};
        end else begin
            u.man = 24'd0;
        end
        return u;
    endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// Combinational 28-bit leading-zero counter; an all-zero input reports 28.
module ahfp_lzc (
    input  logic [27:0] value,
    output logic [4:0]  count
);

    logic found_s;

    // Scan from the MSB and latch the first set bit position.
    always_comb begin
        count   = 5'd28;
        found_s = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found_s && value[i]) begin
                count   = 5'(27 - i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ahfp_add_pipe.sv
// Four-stage IEEE-754 single-precision adder with valid/ready flow control.
// Define AHFP_SPECIAL_EN to add NaN/Inf handling; otherwise exp==255 is an ordinary normal.
module ahfp_add_pipe
    import ahfp_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    logic                stall_s;
    logic [STAGES-1:0]   vld_r;
    logic [31:0]         result_r;

    ahfp_unpacked_t      ua_s, ub_s, big_s, sml_s;
    logic                s1_big_sign_r, s1_sml_sign_r;
    logic [EXP_W-1:0]    s1_exp_r, s1_ediff_r;
    logic [MAN_W:0]      s1_big_man_r, s1_sml_man_r;

    logic [MAN_W+3:0]    ext_s, shr_s, lost_s, sml_al_s;
    logic                s2_sign_r, s2_sub_r;
    logic [EXP_W-1:0]    s2_exp_r;
    logic [MAN_W+3:0]    s2_big_r, s2_sml_r;

    logic [MAN_W+4:0]    sum_s;
    logic                s3_sign_r, s3_sub_r;
    logic [EXP_W-1:0]    s3_exp_r;
    logic [MAN_W+4:0]    s3_sum_r;

    logic [4:0]          lz_s, shl_s;
    logic [MAN_W+3:0]    norm_s;
    logic signed [EXP_W+1:0] e_s;
    logic                inc_s;
    logic [MAN_W+1:0]    rnd_s;
    logic [MAN_W-1:0]    frac_s;
    logic [31:0]         packed_s;

`ifdef AHFP_SPECIAL_EN
    logic nan_s, inf_s, inf_sign_s;
    logic s1_nan_r, s1_inf_r, s1_isgn_r;
    logic s2_nan_r, s2_inf_r, s2_isgn_r;
    logic s3_nan_r, s3_inf_r, s3_isgn_r;
`endif

    assign stall_s   = vld_r[STAGES-1] && !out_ready;
    assign in_ready  = !stall_s;
    assign out_valid = vld_r[STAGES-1];
    assign result    = result_r;

    // S1: unpack both operands and order them by magnitude.
    always_comb begin
        ua_s = ahfp_unpack(dataa);
        ub_s = ahfp_unpack(datab);
        if ({ub_s.exp, ub_s.man} > {ua_s.exp, ua_s.man}) begin
            big_s = ub_s;
            sml_s = ua_s;
        end else begin
            big_s = ua_s;
            sml_s = ub_s;
        end
    end

`ifdef AHFP_SPECIAL_EN
    // S1 special-value classification; Inf-Inf of opposite signs is invalid.
    always_comb begin
        nan_s      = ((dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0)) ||
                     ((datab[30:23] == 8'hFF) && (datab[22:0] != 23'd0));
        inf_s      = 1'b0;
        inf_sign_s = dataa[31];
        if ((dataa[30:23] == 8'hFF) && (datab[30:23] == 8'hFF)) begin
            nan_s = nan_s || (dataa[31] != datab[31]);
            inf_s = 1'b1;
        end else if (dataa[30:23] == 8'hFF) begin
            inf_s = 1'b1;
        end else if (datab[30:23] == 8'hFF) begin
            inf_s      = 1'b1;
            inf_sign_s = datab[31];
        end else begin
            inf_s = 1'b0;
        end
    end
`endif

    // S2: align the small mantissa into a 24+G/R/S field.
    always_comb begin
        ext_s  = {s1_sml_man_r, 3'b000};
        shr_s  = ext_s >> s1_ediff_r;
        lost_s = ext_s & ~({(MAN_W+4){1'b1}} << s1_ediff_r);
        if (s1_ediff_r >= 8'd26) begin
            sml_al_s = {{(MAN_W+3){1'b0}}, |s1_sml_man_r};
        end else begin
            sml_al_s = {shr_s[MAN_W+3:1], shr_s[0] | (|lost_s)};
        end
    end

    // S3: magnitude add or subtract; the S1 ordering keeps the difference non-negative.
    always_comb begin
        if (s2_sub_r) begin
            sum_s = {1'b0, s2_big_r} - {1'b0, s2_sml_r};
        end else begin
            sum_s = {1'b0, s2_big_r} + {1'b0, s2_sml_r};
        end
    end

    ahfp_lzc u_lzc (
        .value (s3_sum_r),
        .count (lz_s)
    );

    // S4: normalise, round to nearest even, and pack with saturation and flush.
    always_comb begin
        shl_s = lz_s - 5'd1;
        if (s3_sum_r[MAN_W+4]) begin
            norm_s = {s3_sum_r[MAN_W+4:2], s3_sum_r[1] | s3_sum_r[0]};
            e_s    = $signed({2'b00, s3_exp_r}) + 10'sd1;
        end else begin
            norm_s = s3_sum_r[MAN_W+3:0] << shl_s;
            e_s    = $signed({2'b00, s3_exp_r}) - $signed({5'd0, shl_s});
        end
        inc_s = norm_s[2] && (norm_s[1] || norm_s[0] || norm_s[3]);
        rnd_s = {1'b0, norm_s[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, inc_s};
        if (rnd_s[MAN_W+1]) begin
            frac_s = rnd_s[MAN_W:1];
            e_s    = e_s + 10'sd1;
        end else begin
            frac_s = rnd_s[MAN_W-1:0];
        end
        if (s3_sum_r == '0) begin
            packed_s = s3_sub_r ? POS_ZERO : {s3_sign_r, 31'd0};
        end else if (e_s <= 10'sd0) begin
            packed_s = {s3_sign_r, 31'd0};
        end else if (e_s >= 10'(EXP_MAX)) begin
            packed_s = {s3_sign_r, 8'hFF, 23'd0};
        end else begin
            packed_s = {s3_sign_r, e_s[EXP_W-1:0], frac_s};
        end
`ifdef AHFP_SPECIAL_EN
        if (s3_nan_r) begin
            packed_s = QNAN;
        end else if (s3_inf_r) begin
            packed_s = {s3_isgn_r, 8'hFF, 23'd0};
        end else begin
            packed_s = packed_s;
        end
`endif
    end

    // Pipeline registers: advance together unless the output is stalled; reset clears all valids.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_r    <= '0;
            result_r <= POS_ZERO;
        end else if (!stall_s) begin
            vld_r         <= {vld_r[STAGES-2:0], in_valid};
            s1_big_sign_r <= big_s.sign;
            s1_sml_sign_r <= sml_s.sign;
            s1_exp_r      <= big_s.exp;
            s1_ediff_r    <= big_s.exp - sml_s.exp;
            s1_big_man_r  <= big_s.man;
            s1_sml_man_r  <= sml_s.man;
            s2_sign_r     <= s1_big_sign_r;
            s2_sub_r      <= s1_big_sign_r ^ s1_sml_sign_r;
            s2_exp_r      <= s1_exp_r;
            s2_big_r      <= {s1_big_man_r, 3'b000};
            s2_sml_r      <= sml_al_s;
            s3_sign_r     <= s2_sign_r;
            s3_sub_r      <= s2_sub_r;
            s3_exp_r      <= s2_exp_r;
            s3_sum_r      <= sum_s;
`ifdef AHFP_SPECIAL_EN
            s1_nan_r      <= nan_s;
            s1_inf_r      <= inf_s;
            s1_isgn_r     <= inf_sign_s;
            s2_nan_r      <= s1_nan_r;
            s2_inf_r      <= s1_inf_r;
            s2_isgn_r     <= s1_isgn_r;
            s3_nan_r      <= s2_nan_r;
            s3_inf_r      <= s2_inf_r;
            s3_isgn_r     <= s2_isgn_r;
`endif
            if (vld_r[STAGES-2]) begin
                result_r <= packed_s;
            end else begin
                result_r <= result_r;
            end
        end else begin
            vld_r    <= vld_r;
            result_r <= result_r;
        end
    end

endmodule
